// File: rtl/api_dispatch.sv
// Work dispatcher: pops WORK_LEN-word packets from TX FIFO, shifts each to a round-robin chip, returns nonces.
// Latency: 1 PICK + WORK_LEN*64*D SHIFT + cfg_gap GAP + 1 IDLE cycle per packet (D = max(cfg_sck,1)).
// Backpressure: starts a packet only with a full packet in TX and RX_LEN free RX slots; never stalls mid-packet.
module api_dispatch #(
    parameter int CH_NUM   = 8,
    parameter int CH_W     = 4,
    parameter int WORK_LEN = 23,
    parameter int RX_LEN   = 2,
    parameter int RX_DEPTH = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_en,
    input  logic [7:0]        cfg_sck,
    input  logic [CH_NUM-1:0] cfg_ch_mask,
    input  logic [27:0]       cfg_gap,
    input  logic [10:0]       tx_cnt,
    input  logic [31:0]       tx_dout,
    output logic              tx_rd_en,
    input  logic [9:0]        rx_cnt,
    output logic              rx_wr_en,
    output logic [31:0]       rx_din,
    output logic [CH_W-1:0]   rx_ch,
    output logic [CH_NUM-1:0] load,
    output logic              sck,
    output logic              mosi,
    input  logic [CH_NUM-1:0] miso,
    output logic [1:0]        state,
    output logic [CH_W-1:0]   cur_ch
);

    localparam int WI_W = $clog2(WORK_LEN + 1);
    localparam logic [WI_W-1:0]   LAST_WORD = WI_W'(WORK_LEN - 1);
    localparam logic [WI_W-1:0]   FIRST_RX  = WI_W'(WORK_LEN - RX_LEN);
    localparam logic [CH_NUM-1:0] CH_ONE    = CH_NUM'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PICK  = 2'd1,
        SHIFT = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       sh_q, cap_q;
    logic [WI_W-1:0]   word_q;
    logic [4:0]        bit_q;
    logic              phase_q;
    logic [7:0]        div_q, half_q;
    logic [27:0]       gap_q;
    logic [CH_W-1:0]   pick_q, nxt_ch, rr_hi, rr_lo;
    logic              rr_hit;
    logic              start_ok, half_end, bit_end, word_end, last_word, miso_bit;

    assign start_ok = cfg_en && (cfg_ch_mask != '0)
                      && (32'(tx_cnt) >= 32'(WORK_LEN))
                      && (32'(rx_cnt) + 32'(RX_LEN) <= 32'(RX_DEPTH));

    assign half_end  = (div_q == half_q - 8'd1);
    assign bit_end   = (state_q == SHIFT) && phase_q && half_end;
    assign word_end  = bit_end && (bit_q == 5'd31);
    assign last_word = (word_q == LAST_WORD);
    assign miso_bit  = |(miso & (CH_ONE << cur_ch));
    assign state     = state_q;

    // Next channel: lowest mask bit above cur_ch, else lowest mask bit overall (wrap).
    always_comb begin
        rr_hi  = '0;
        rr_lo  = '0;
        rr_hit = 1'b0;
        for (int j = CH_NUM - 1; j >= 0; j--) begin
            if (cfg_ch_mask[j]) begin
                rr_lo = CH_W'(j);
                if (CH_W'(j) > cur_ch) begin
                    rr_hi  = CH_W'(j);
                    rr_hit = 1'b1;
                end
            end
        end
        nxt_ch = rr_hit ? rr_hi : rr_lo;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = PICK;
            PICK:    state_d = SHIFT;
            SHIFT:   if (word_end && last_word) state_d = (cfg_gap == '0) ? IDLE : GAP;
            GAP:     if (gap_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_rd_en = 1'b0;
        load     = '0;
        sck      = 1'b0;
        mosi     = 1'b0;
        case (state_q)
            PICK: tx_rd_en = 1'b1;
            SHIFT: begin
                load     = CH_ONE << cur_ch;
                sck      = phase_q;
                mosi     = sh_q[31];
                tx_rd_en = word_end && !last_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_ch   <= CH_W'(CH_NUM - 1);
            pick_q   <= '0;
            sh_q     <= '0;
            cap_q    <= '0;
            word_q   <= '0;
            bit_q    <= '0;
            phase_q  <= 1'b0;
            div_q    <= '0;
            half_q   <= 8'd1;
            gap_q    <= '0;
            rx_wr_en <= 1'b0;
            rx_din   <= '0;
            rx_ch    <= '0;
        end else begin
            rx_wr_en <= 1'b0;
            case (state_q)
                // Channel choice is frozen with the mask seen at the start decision.
                IDLE: pick_q <= nxt_ch;
                PICK: begin
                    cur_ch  <= pick_q;
                    half_q  <= (cfg_sck == 8'd0) ? 8'd1 : cfg_sck;
                    sh_q    <= tx_dout;
                    word_q  <= '0;
                    bit_q   <= '0;
                    phase_q <= 1'b0;
                    div_q   <= '0;
                end
                SHIFT: begin
                    if (half_end) begin
                        div_q   <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        div_q <= div_q + 8'd1;
                    end
                    if (!phase_q && half_end)
                        cap_q <= {cap_q[30:0], miso_bit};
                    if (bit_end) begin
                        bit_q <= bit_q + 5'd1;
                        sh_q  <= {sh_q[30:0], 1'b0};
                        if (bit_q == 5'd31) begin
                            if (!last_word) begin
                                sh_q   <= tx_dout;
                                word_q <= word_q + WI_W'(1);
                            end else begin
                                gap_q <= cfg_gap - 28'd1;
                            end
                            // All-ones means the chip found nothing; drop it.
                            if (word_q >= FIRST_RX && cap_q != '1) begin
                                rx_wr_en <= 1'b1;
                                rx_din   <= cap_q;
                                rx_ch    <= cur_ch;
                            end
                        end
                    end
                end
                GAP: if (gap_q != '0) gap_q <= gap_q - 28'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_api_dispatch.sv
// Directed bench for api_dispatch: FWFT TX FIFO model, chip miso responder,
// bus monitors, and immediate-assertion checks against hand-computed values.
module tb_api_dispatch;

    localparam int CH_NUM   = 8;
    localparam int CH_W     = 4;
    localparam int WORK_LEN = 23;
    localparam int RX_LEN   = 2;
    localparam int RX_DEPTH = 512;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cfg_en;
    logic [7:0]        cfg_sck;
    logic [CH_NUM-1:0] cfg_ch_mask;
    logic [27:0]       cfg_gap;
    logic [10:0]       tx_cnt;
    logic [31:0]       tx_dout;
    logic              tx_rd_en;
    logic [9:0]        rx_cnt;
    logic              rx_wr_en;
    logic [31:0]       rx_din;
    logic [CH_W-1:0]   rx_ch;
    logic [CH_NUM-1:0] load;
    logic              sck;
    logic              mosi;
    logic [CH_NUM-1:0] miso;
    logic [1:0]        state;
    logic [CH_W-1:0]   cur_ch;

    int vectors = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    api_dispatch #(
        .CH_NUM(CH_NUM), .CH_W(CH_W), .WORK_LEN(WORK_LEN), .RX_LEN(RX_LEN), .RX_DEPTH(RX_DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .cfg_sck(cfg_sck),
        .cfg_ch_mask(cfg_ch_mask), .cfg_gap(cfg_gap), .tx_cnt(tx_cnt), .tx_dout(tx_dout),
        .tx_rd_en(tx_rd_en), .rx_cnt(rx_cnt), .rx_wr_en(rx_wr_en), .rx_din(rx_din),
        .rx_ch(rx_ch), .load(load), .sck(sck), .mosi(mosi), .miso(miso),
        .state(state), .cur_ch(cur_ch)
    );

    // TX FIFO model (first-word-fall-through)
    logic [31:0] tx_mem [0:255];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign tx_cnt  = 11'(wr_ptr - rd_ptr);
    assign tx_dout = tx_mem[rd_ptr % 256];
    always @(posedge clk) if (tx_rd_en) rd_ptr <= rd_ptr + 1;

    // Chip model: returns miso_pat word-by-word on the selected channel, inverse on the others
    logic [31:0] miso_pat [0:WORK_LEN-1];
    initial begin
        int rc, w, b;
        logic ps, bv;
        miso = '0;
        rc = 0;
        ps = 1'b0;
        forever begin
            @(negedge clk);
            if (load == '0) rc = 0;
            else if (sck && !ps) rc++;
            ps = sck;
            w = rc / 32;
            b = 31 - (rc % 32);
            if (w > WORK_LEN - 1) w = WORK_LEN - 1;
            bv = miso_pat[w][b];
            miso = bv ? load : ~load;
        end
    end

    // Monitors
    int pop_cnt = 0, consec_cnt = 0, load_cyc = 0, bad_load = 0, gap_cyc = 0;
    int rx_n = 0, seq_n = 0, mosi_n = 0, mbits = 0, cyc = 0;
    int lcnt = 0, first_rise = -1, rise_seen = 0, last_rise_at = 0;
    int sck_per = 0, hi_run = 0, sck_hi = 0;
    logic [31:0] rx_log_din [0:15];
    logic [3:0]  rx_log_ch  [0:15];
    int          seq_log    [0:15];
    logic [31:0] mosi_log   [0:255];
    logic [31:0] mosi_acc = '0;
    logic        p_rd = 1'b0, p_sck = 1'b0;
    logic [CH_NUM-1:0] p_load = '0;

    always @(negedge clk) begin
        cyc++;
        if (tx_rd_en) begin
            pop_cnt++;
            if (p_rd) consec_cnt++;
        end
        if (load != '0) begin
            load_cyc++;
            if (!$onehot(load)) bad_load++;
            if (p_load == '0) begin
                lcnt = 0;
                rise_seen = 0;
                mbits = 0;
                for (int i = 0; i < CH_NUM; i++) if (load[i]) seq_log[seq_n % 16] = i;
                seq_n++;
            end else begin
                lcnt++;
            end
        end
        if (state == 2'd3) gap_cyc++;
        if (sck && !p_sck) begin
            if (rise_seen == 0) first_rise = lcnt;
            else sck_per = cyc - last_rise_at;
            rise_seen++;
            last_rise_at = cyc;
            mosi_acc = {mosi_acc[30:0], mosi};
            mbits++;
            if (mbits == 32) begin
                mosi_log[mosi_n % 256] = mosi_acc;
                mosi_n++;
                mbits = 0;
            end
        end
        if (sck) hi_run++;
        else begin
            if (p_sck) sck_hi = hi_run;
            hi_run = 0;
        end
        if (rx_wr_en) begin
            rx_log_din[rx_n % 16] = rx_din;
            rx_log_ch[rx_n % 16]  = rx_ch;
            rx_n++;
        end
        p_rd   = tx_rd_en;
        p_sck  = sck;
        p_load = load;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_state(input logic [1:0] s, input int lim, input string tag);
        int n = 0;
        while (state !== s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic wait_leave(input logic [1:0] s, input int lim, input string tag);
        int n = 0;
        while (state === s && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(state !== s), 32'd1);
    endtask

    task automatic push(input logic [31:0] w);
        tx_mem[wr_ptr % 256] = w;
        wr_ptr++;
    endtask

    initial begin
        int p0, l0, r0, m0, s0, c0, g0, n;

        rst_n = 1'b1;
        cfg_en = 1'b0;
        cfg_sck = 8'd1;
        cfg_ch_mask = 8'h01;
        cfg_gap = '0;
        rx_cnt = '0;
        for (int i = 0; i < WORK_LEN; i++) miso_pat[i] = 32'hFFFF_FFFF;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_state",  32'(state),    32'd0);
        chk("rst_cur_ch", 32'(cur_ch),   32'd7);
        chk("rst_load",   32'(load),     32'd0);
        chk("rst_sck",    32'(sck),      32'd0);
        chk("rst_mosi",   32'(mosi),     32'd0);
        chk("rst_tx_rd",  32'(tx_rd_en), 32'd0);
        chk("rst_rx_wr",  32'(rx_wr_en), 32'd0);
        chk("rst_rx_din", rx_din,        32'd0);
        chk("rst_rx_ch",  32'(rx_ch),    32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single channel, words 1..23, nonce in word 21, none in word 22
        miso_pat[21] = 32'hDEAD_BEEF;
        for (int i = 1; i <= WORK_LEN; i++) push(32'(i));
        p0 = pop_cnt; l0 = load_cyc; r0 = rx_n; m0 = mosi_n; c0 = consec_cnt;
        cfg_en = 1'b1;
        wait_state(2'd1, 5, "t1_pick");
        chk("t1_pick_rd",  32'(tx_rd_en), 32'd1);
        chk("t1_pick_ch",  32'(cur_ch),   32'd7);
        wait_state(2'd2, 4, "t1_shift");
        chk("t1_load0",    32'(load),     32'h01);
        chk("t1_sck0",     32'(sck),      32'd0);
        chk("t1_cur_ch",   32'(cur_ch),   32'd0);
        wait_leave(2'd2, 1600, "t1_end");
        repeat (3) @(negedge clk);
        chk("t1_idle",     32'(state),    32'd0);
        chk("t1_pops",     32'(pop_cnt - p0),    32'd23);
        chk("t1_consec",   32'(consec_cnt - c0), 32'd0);
        chk("t1_load_cyc", 32'(load_cyc - l0),   32'd1472);
        chk("t1_onehot",   32'(bad_load),        32'd0);
        chk("t1_rx_n",     32'(rx_n - r0),       32'd1);
        chk("t1_rx_din",   rx_log_din[r0 % 16],  32'hDEAD_BEEF);
        chk("t1_rx_ch",    32'(rx_log_ch[r0 % 16]), 32'd0);
        chk("t1_first",    32'(first_rise),      32'd1);
        chk("t1_per",      32'(sck_per),         32'd2);
        chk("t1_hi",       32'(sck_hi),          32'd1);
        chk("t1_mosi_n",   32'(mosi_n - m0),     32'd23);
        for (int k = 0; k < WORK_LEN; k++) chk("t1_mosi_word", mosi_log[(m0 + k) % 256], 32'(k + 1));

        // RX backpressure, then slow SCK with a gap; all-ones returns are dropped
        cfg_en = 1'b0;
        rx_cnt = 10'd511;
        cfg_sck = 8'd4;
        cfg_gap = 28'd10;
        miso_pat[21] = 32'hFFFF_FFFF;
        for (int i = 0; i < WORK_LEN; i++) push(32'hA5A5_0000 + 32'(i));
        p0 = pop_cnt; l0 = load_cyc; r0 = rx_n; m0 = mosi_n; g0 = gap_cyc;
        cfg_en = 1'b1;
        repeat (20) @(negedge clk);
        chk("t2_hold_state", 32'(state),         32'd0);
        chk("t2_hold_pops",  32'(pop_cnt - p0),  32'd0);
        rx_cnt = 10'd510;
        wait_state(2'd1, 5, "t2_pick");
        wait_state(2'd2, 4, "t2_shift");
        wait_leave(2'd2, 6000, "t2_end");
        chk("t2_gap_state",  32'(state),         32'd3);
        wait_state(2'd0, 20, "t2_idle");
        repeat (3) @(negedge clk);
        chk("t2_gap_cyc",    32'(gap_cyc - g0),  32'd10);
        chk("t2_load_cyc",   32'(load_cyc - l0), 32'd5888);
        chk("t2_pops",       32'(pop_cnt - p0),  32'd23);
        chk("t2_rx_n",       32'(rx_n - r0),     32'd0);
        chk("t2_first",      32'(first_rise),    32'd4);
        chk("t2_per",        32'(sck_per),       32'd8);
        chk("t2_hi",         32'(sck_hi),        32'd4);
        chk("t2_mosi_first", mosi_log[m0 % 256],        32'hA5A5_0000);
        chk("t2_mosi_last",  mosi_log[(m0 + 22) % 256], 32'hA5A5_0016);
        chk("t2_cur_ch",     32'(cur_ch),        32'd0);

        // Round-robin over mask 0x0A, cfg_sck=0 -> D=1, enable dropped during the third packet
        cfg_en = 1'b0;
        rx_cnt = '0;
        cfg_sck = 8'd0;
        cfg_gap = '0;
        cfg_ch_mask = 8'h0A;
        miso_pat[21] = 32'h1234_5678;
        miso_pat[22] = 32'h0000_0000;
        for (int i = 0; i < 3 * WORK_LEN; i++) push(32'h3C00_0000 + 32'(i));
        p0 = pop_cnt; r0 = rx_n; s0 = seq_n; c0 = consec_cnt;
        cfg_en = 1'b1;
        n = 0;
        while (pop_cnt - p0 < 50 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        cfg_en = 1'b0;
        n = 0;
        while (!(pop_cnt - p0 == 69 && state == 2'd0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("t3_pops",   32'(pop_cnt - p0),    32'd69);
        chk("t3_state",  32'(state),           32'd0);
        chk("t3_consec", 32'(consec_cnt - c0), 32'd0);
        chk("t3_seq_n",  32'(seq_n - s0),      32'd3);
        chk("t3_seq0",   32'(seq_log[s0 % 16]),       32'd1);
        chk("t3_seq1",   32'(seq_log[(s0 + 1) % 16]), 32'd3);
        chk("t3_seq2",   32'(seq_log[(s0 + 2) % 16]), 32'd1);
        chk("t3_cur_ch", 32'(cur_ch),          32'd1);
        chk("t3_per",    32'(sck_per),         32'd2);
        chk("t3_rx_n",   32'(rx_n - r0),       32'd6);
        for (int k = 0; k < 6; k++) begin
            chk("t3_rx_ch",  32'(rx_log_ch[(r0 + k) % 16]), (k / 2 == 1) ? 32'd3 : 32'd1);
            chk("t3_rx_din", rx_log_din[(r0 + k) % 16], (k % 2 == 0) ? 32'h1234_5678 : 32'h0);
        end

        // Reset while shifting word 5: everything clears at once, nothing partial is pushed
        cfg_ch_mask = 8'h01;
        cfg_sck = 8'd1;
        miso_pat[21] = 32'hCAFE_F00D;
        for (int i = 0; i < WORK_LEN; i++) push(32'h7700_0000 + 32'(i));
        p0 = pop_cnt; r0 = rx_n;
        cfg_en = 1'b1;
        n = 0;
        while (pop_cnt - p0 < 6 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        cfg_en = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_mid_state", 32'(state), 32'd2);
        chk("t4_mid_load",  32'(load),  32'h01);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_load",  32'(load),     32'd0);
        chk("t4_rst_sck",   32'(sck),      32'd0);
        chk("t4_rst_mosi",  32'(mosi),     32'd0);
        chk("t4_rst_state", 32'(state),    32'd0);
        chk("t4_rst_cur",   32'(cur_ch),   32'd7);
        chk("t4_rst_rd",    32'(tx_rd_en), 32'd0);
        chk("t4_rst_wr",    32'(rx_wr_en), 32'd0);
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_rx_n",   32'(rx_n - r0),    32'd0);
        chk("t4_pops",   32'(pop_cnt - p0), 32'd6);
        chk("t4_state",  32'(state),        32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
